// File: rtl/ov7670_config_seq_if.sv
// Write-command channel between the config sequencer and the SCCB write engine.
interface ov7670_config_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       sccb_busy;

  modport master (
    output cmd_valid,
    output cmd_reg,
    output cmd_data,
    input  cmd_ready,
    input  sccb_busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_reg,
    input  cmd_data,
    output cmd_ready,
    output sccb_busy
  );
endinterface

// File: rtl/ov7670_config_seq.sv
// OV7670 init sequencer: walks the config ROM from address 0 and issues one SCCB write per
// entry. 16'hFFF0 inserts a settle delay once the SCCB engine is idle, 16'hFFFF ends the table.
module ov7670_config_seq #(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned DELAY_MS    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  output logic [7:0]                 rom_addr_o,
  input  logic [15:0]                rom_data_i,
  ov7670_config_seq_if.master        cmd_if,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [7:0]                 wr_count_o
);

  localparam int unsigned DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
  localparam int unsigned CntW         = $clog2(DELAY_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StDecode, StIssue, StDrain, StDelay, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      rom_addr_q, rom_addr_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      cmd_reg_q, cmd_reg_d;
  logic [7:0]      cmd_data_q, cmd_data_d;
  logic [7:0]      wr_count_q, wr_count_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Remembers whether DRAIN was entered for end-of-table (1) or for a settle delay (0).
  logic            is_end_q, is_end_d;

  // State register; reset drops cmd_valid asynchronously and clears all progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rom_addr_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_reg_q   <= '0;
      cmd_data_q  <= '0;
      wr_count_q  <= '0;
      cnt_q       <= '0;
      is_end_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_data_q  <= cmd_data_d;
      wr_count_q  <= wr_count_d;
      cnt_q       <= cnt_d;
      is_end_q    <= is_end_d;
    end
  end

  // Next-state logic: fetch, decode markers, handshake writes, drain and delay.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_data_d  = cmd_data_q;
    wr_count_d  = wr_count_q;
    cnt_d       = cnt_q;
    is_end_d    = is_end_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          rom_addr_d = '0;
          wr_count_d = '0;
          state_d    = StFetch;
        end
      end
      StFetch:  state_d = StWait;
      StWait:   state_d = StDecode;
      StDecode: begin
        if (rom_data_i == 16'hFFFF) begin
          is_end_d = 1'b1;
          state_d  = StDrain;
        end else if (rom_data_i == 16'hFFF0) begin
          is_end_d = 1'b0;
          state_d  = StDrain;
        end else begin
          cmd_reg_d   = rom_data_i[15:8];
          cmd_data_d  = rom_data_i[7:0];
          cmd_valid_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (cmd_valid_q && cmd_if.cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
          // The table never wraps past the last ROM address.
          if (rom_addr_q == 8'hFF) begin
            is_end_d = 1'b1;
            state_d  = StDrain;
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = StFetch;
          end
        end
      end
      StDrain: begin
        if (!cmd_if.sccb_busy) begin
          if (is_end_q) begin
            state_d = StDone;
          end else begin
            cnt_d   = CntW'(DELAY_CYCLES - 1);
            state_d = StDelay;
          end
        end
      end
      StDelay: begin
        if (cnt_q == '0) begin
          if (rom_addr_q == 8'hFF) begin
            state_d = StDone;
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = StFetch;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    busy_o           = (state_q != StIdle) && (state_q != StDone);
    done_o           = (state_q == StDone);
    rom_addr_o       = rom_addr_q;
    wr_count_o       = wr_count_q;
    cmd_if.cmd_valid = cmd_valid_q;
    cmd_if.cmd_reg   = cmd_reg_q;
    cmd_if.cmd_data  = cmd_data_q;
  end

endmodule
